// File: rtl/halt_mem_dump.sv
// halt_mem_dump: on a halt encoding, drain the pipeline, then scan data memory and stream nonzero words over valid/ready
module halt_mem_dump #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DRAIN_CYCLES = 10,
  parameter bit SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  output logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic [ADDR_W:0]   dump_count
);
  typedef enum logic [2:0] {RUN, DRAIN, RD, CHK, EMIT, DONE} state_t;
  state_t state;
  logic [31:0] drain_cnt;
  logic halt_hit, last, keep;
  always_comb begin
    halt_hit = instr == DATA_W'(16'hE000) || instr == DATA_W'(16'hE7FF);
    last = &mem_rd_addr;
    keep = mem_rd_data != '0 || !SKIP_ZERO;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      drain_cnt <= '0;
      halted <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_rd_addr <= '0;
      dump_valid <= 1'b0;
      dump_addr <= '0;
      dump_data <= '0;
      dump_done <= 1'b0;
      dump_count <= '0;
    end else begin
      case (state)
        RUN: if (halt_hit) begin
          halted <= 1'b1;
          drain_cnt <= '0;
          mem_rd_addr <= '0;
          mem_rd_en <= DRAIN_CYCLES == 0;
          state <= DRAIN_CYCLES == 0 ? RD : DRAIN;
        end
        DRAIN: if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
          mem_rd_en <= 1'b1;
          state <= RD;
        end else drain_cnt <= drain_cnt + 32'd1;
        RD: begin
          mem_rd_en <= 1'b0;
          state <= CHK;
        end
        CHK: if (keep) begin
          dump_addr <= mem_rd_addr;
          dump_data <= mem_rd_data;
          dump_valid <= 1'b1;
          state <= EMIT;
        end else if (last) begin
          dump_done <= 1'b1;
          state <= DONE;
        end else begin
          mem_rd_addr <= mem_rd_addr + 1'b1;
          mem_rd_en <= 1'b1;
          state <= RD;
        end
        EMIT: if (dump_ready) begin
          dump_valid <= 1'b0;
          dump_count <= dump_count + 1'b1;
          if (last) begin
            dump_done <= 1'b1;
            state <= DONE;
          end else begin
            mem_rd_addr <= mem_rd_addr + 1'b1;
            mem_rd_en <= 1'b1;
            state <= RD;
          end
        end
        DONE: ;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: doc/halt_mem_dump.md
# halt_mem_dump

Post-execution result extractor sitting directly downstream of the 16-bit pipelined CPU core and its data memory. It watches the core's decoded instruction for the halt encodings. On halt it waits a fixed number of cycles so the pipeline can drain. It then scans the data memory through a dedicated synchronous read port and streams every nonzero word, with its address, over a valid/ready interface to the result sink (host link or file-writer model), then flags completion.

## Interface
Parameters:
- ADDR_W, 16, data-memory address width; scan covers 0 .. 2^ADDR_W-1
- DATA_W, 16, data-memory word width; also the instruction width
- DRAIN_CYCLES, 10, cycles waited after halt detection before the first read
- SKIP_ZERO, 1, 1 = emit only nonzero words; 0 = emit every word

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- instr  in  DATA_W  current instruction from core decode stage
- halted  out  1  sticky, high from halt detection until reset
- mem_rd_en  out  1  read strobe to data-memory dump port
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- dump_valid  out  1  output beat valid
- dump_ready  in  1  sink accepts beat
- dump_addr  out  ADDR_W  address of emitted word
- dump_data  out  DATA_W  emitted word
- dump_done  out  1  sticky, scan complete
- dump_count  out  ADDR_W+1  number of beats accepted

## Operation
- Halt match: instr == 16'hE000 or instr == 16'hE7FF; no other value triggers. Only sampled in RUN.
- States: RUN, DRAIN, RD, CHK, EMIT, DONE.
- RUN: on halt match -> DRAIN, halted<=1, drain counter<=0, scan address<=0.
- DRAIN: counter increments each cycle; after DRAIN_CYCLES cycles in DRAIN -> RD. With DRAIN_CYCLES=0, go directly RUN->RD.
- RD: mem_rd_en=1, mem_rd_addr=scan address; -> CHK.
- CHK: mem_rd_data is valid. If data!=0 or SKIP_ZERO=0, latch data/address into dump regs and go -> EMIT. Otherwise, if the address is the last one -> DONE, else address+1 -> RD.
- EMIT: dump_valid=1. dump_addr/dump_data held stable until dump_valid&&dump_ready. On that handshake: dump_count+1, then -> DONE if last address, else address+1 -> RD.
- DONE: dump_done=1, all strobes low, stays until reset; further halt encodings ignored.
- Last address = all ones in ADDR_W bits; the address never wraps to 0 and re-scans.
- dump_count saturates nowhere; ADDR_W+1 bits holds the full 2^ADDR_W maximum.
- Reset in any state: return to RUN, all counters and registers cleared; a partial scan is abandoned, not resumed.

## Timing
- Reset values: halted=0, mem_rd_en=0, mem_rd_addr=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0, dump_count=0.
- Halt matched at edge T: halted high after T. First mem_rd_en in cycle T+DRAIN_CYCLES+1.
- Per word: skipped word takes 2 cycles (RD, CHK). Emitted word takes 3 cycles plus stall cycles while dump_ready is low.
- dump_valid is asserted from a register, never combinationally from dump_ready; it does not drop without a handshake.
- dump_done rises the cycle after the final CHK or final EMIT handshake.
- mem_rd_en is high exactly one cycle per address; there are no reads outside RD.

## Test plan
- Reset/idle: hold reset 4 cycles with instr toggling random non-halt values, incl. 16'hE001 and 16'hE7FE -> all outputs at reset values, halted stays 0.
- Basic dump (ADDR_W=4, DRAIN_CYCLES=10): mem[2]=16'h1234, mem[9]=16'h00FF, mem[15]=16'hFFFF, rest 0. Drive instr=16'hE000 at edge T -> first mem_rd_en at T+11. Beats in order (2,1234),(9,00FF),(F,FFFF); dump_count=3; dump_done=1; exactly 16 read strobes.
- Alternate halt: same memory, halt via 16'hE7FF -> identical beat sequence.
- Backpressure: dump_ready low for 5 cycles during the first beat -> dump_valid, dump_addr=2, and dump_data=1234 stay stable all 5 cycles; no further mem_rd_en until accepted; count increments once.
- All-zero memory, SKIP_ZERO=0 vs 1: SKIP_ZERO=1 -> no beats, dump_done after 32 scan cycles, count=0. SKIP_ZERO=0 -> 16 beats of data 0 at addresses 0..15, count=16.
- Reset mid-scan: assert reset during EMIT of address 9 -> next cycle all outputs at reset values. A new halt restarts the scan from address 0 and delivers all three beats.
